// File: rtl/otp_xor_sched_if.sv
// Bundle of SD-ctrl level handshake, gamma-generator handshake and RAM ports
// for otp_xor_sched; slave = scheduler side, master = environment side.
interface otp_xor_sched_if #(
    parameter int ADDR_W  = 10,
    parameter int BLOCK_W = 64
);
    logic               igen;
    logic               inew;
    logic               oready;
    logic               ogamma_new;
    logic               ogamma_req;
    logic               igamma_valid;
    logic [BLOCK_W-1:0] igamma;
    logic [ADDR_W-1:0]  oraddr;
    logic [3:0]         irdata;
    logic [ADDR_W-1:0]  owaddr;
    logic [3:0]         owdata;
    logic               owe;

    modport slave (
        input  igen, inew, igamma_valid, igamma, irdata,
        output oready, ogamma_new, ogamma_req, oraddr, owaddr, owdata, owe
    );

    modport master (
        output igen, inew, igamma_valid, igamma, irdata,
        input  oready, ogamma_new, ogamma_req, oraddr, owaddr, owdata, owe
    );
endinterface

// File: rtl/otp_xor_sched.sv
// Sector-wide XOR of receive-RAM nibbles with OTP blocks into the transmit RAM.
// Define OTP_SCHED_PREFETCH_EN to double-buffer the pad and remove REQ/WAIT gaps.
module otp_xor_sched #(
    parameter int ADDR_W  = 10,
    parameter int BLOCK_W = 64
) (
    input  logic           iclk,
    input  logic           irst,
    otp_xor_sched_if.slave bus
);
    localparam int NIB_PER_BLK = BLOCK_W / 4;
    localparam int NIB_W       = $clog2(NIB_PER_BLK);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_RUN,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t             state;
    logic [ADDR_W-1:0]  cnt;
    logic [ADDR_W-1:0]  waddr;
    logic [BLOCK_W-1:0] gbuf;
    logic [3:0]         gnib;
    logic               inew_d;
    logic               we;
    logic               ready;
    logic               gamma_new;
    logic               gamma_req;
    logic               blk_end;
    logic               sect_end;

    assign blk_end  = &cnt[NIB_W-1:0];
    assign sect_end = &cnt;

`ifdef OTP_SCHED_PREFETCH_EN
    logic [BLOCK_W-1:0] gnext;
    logic               gfull;
    logic               pend;
    logic               have_next;
    logic               last_blk;
    logic               next_last;

    assign have_next = gfull || (pend && bus.igamma_valid);
    assign last_blk  = &cnt[ADDR_W-1:NIB_W];
    assign next_last = (&cnt[ADDR_W-1:NIB_W+1]) && !cnt[NIB_W];
`endif

    always_ff @(posedge iclk) begin
        if (irst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            waddr     <= '0;
            gbuf      <= '0;
            gnib      <= '0;
            inew_d    <= 1'b0;
            we        <= 1'b0;
            ready     <= 1'b0;
            gamma_new <= 1'b0;
            gamma_req <= 1'b0;
`ifdef OTP_SCHED_PREFETCH_EN
            gnext     <= '0;
            gfull     <= 1'b0;
            pend      <= 1'b0;
`endif
        end else begin
            inew_d    <= bus.inew;
            gamma_new <= 1'b0;
            gamma_req <= 1'b0;
            we        <= 1'b0;
`ifdef OTP_SCHED_PREFETCH_EN
            // Outstanding block landing outside WAIT goes to the spare buffer.
            if (pend && bus.igamma_valid && state != S_WAIT) begin
                gnext <= bus.igamma;
                gfull <= 1'b1;
                pend  <= 1'b0;
            end
`endif
            case (state)
                S_IDLE: begin
                    // IV reload wins over a simultaneous start so it precedes the first request.
                    if (bus.inew && !inew_d) begin
                        gamma_new <= 1'b1;
`ifdef OTP_SCHED_PREFETCH_EN
                    end else if (bus.igen && !pend) begin
                        gfull     <= 1'b0;
                        pend      <= 1'b1;
`else
                    end else if (bus.igen) begin
`endif
                        cnt       <= '0;
                        gamma_req <= 1'b1;
                        state     <= S_REQ;
                    end
                end
                S_REQ: state <= S_WAIT;
                S_WAIT: begin
                    if (bus.igamma_valid) begin
                        gbuf  <= bus.igamma;
                        state <= bus.igen ? S_RUN : S_IDLE;
`ifdef OTP_SCHED_PREFETCH_EN
                        pend  <= 1'b0;
                        if (bus.igen && !last_blk) begin
                            gamma_req <= 1'b1;
                            pend      <= 1'b1;
                        end
`endif
                    end
                end
                S_RUN: begin
                    cnt   <= cnt + 1'b1;
                    we    <= 1'b1;
                    waddr <= cnt;
                    gnib  <= gbuf[{cnt[NIB_W-1:0], 2'b00} +: 4];
                    if (blk_end) begin
                        if (sect_end) begin
                            state <= S_FLUSH;
                        end else if (!bus.igen) begin
                            state <= S_IDLE;
                        end else begin
`ifdef OTP_SCHED_PREFETCH_EN
                            if (have_next) begin
                                gbuf  <= gfull ? gnext : bus.igamma;
                                gfull <= 1'b0;
                                pend  <= 1'b0;
                                if (!next_last) begin
                                    gamma_req <= 1'b1;
                                    pend      <= 1'b1;
                                end
                            end else begin
                                state <= S_WAIT;
                            end
`else
                            gamma_req <= 1'b1;
                            state     <= S_REQ;
`endif
                        end
                    end
                end
                S_FLUSH: begin
                    ready <= 1'b1;
                    state <= S_DONE;
                end
                S_DONE: begin
                    if (!bus.igen) begin
                        ready <= 1'b0;
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.oraddr     = cnt;
    assign bus.owaddr     = waddr;
    assign bus.owe        = we;
    assign bus.owdata     = we ? (bus.irdata ^ gnib) : 4'h0;
    assign bus.oready     = ready;
    assign bus.ogamma_new = gamma_new;
    assign bus.ogamma_req = gamma_req;
endmodule

// File: tb/tb_otp_xor_sched.sv
// Directed bench for otp_xor_sched: RAM and gamma-generator models, table-driven Tx RAM checks.
module tb_otp_xor_sched;
    localparam int ADDR_W  = 10;
    localparam int BLOCK_W = 64;
    localparam int N       = 1 << ADDR_W;

`ifdef OTP_SCHED_PREFETCH_EN
    localparam int EXP_A_CYC   = 1031;
    localparam int EXP_B_CYC   = 1032;
    localparam int EXP_DROP_RQ = 8;
    localparam int DROP_BLK    = 8;
`else
    localparam int EXP_A_CYC   = 1283;
    localparam int EXP_B_CYC   = 1410;
    localparam int EXP_DROP_RQ = 7;
    localparam int DROP_BLK    = 7;
`endif

    typedef struct {
        int unsigned addr;
        logic [3:0]  exp;
    } vec_t;

    logic iclk = 1'b0;
    logic irst = 1'b1;
    always #5 iclk = ~iclk;

    otp_xor_sched_if #(.ADDR_W(ADDR_W), .BLOCK_W(BLOCK_W)) bus ();
    otp_xor_sched #(.ADDR_W(ADDR_W), .BLOCK_W(BLOCK_W)) dut (
        .iclk (iclk),
        .irst (irst),
        .bus  (bus)
    );

    logic [3:0]  rx [N];
    logic [3:0]  tx [N];
    int unsigned wr_cnt [N];
    int unsigned checks = 0, errors = 0;
    int unsigned cyc = 0, n_req = 0, n_new = 0, n_wr = 0, max_waddr = 0;
    int unsigned first_we = 0, last_we = 0, gcd = 0, blk_ctr = 0, lg = 3;
    bit          gen_mode = 1'b0;
    bit          seen_ready = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Receive RAM: synchronous read, one cycle latency.
    always @(posedge iclk) bus.irdata <= rx[bus.oraddr];

    // Monitor and gamma generator, both away from the active edge.
    always @(negedge iclk) begin
        cyc++;
        if (bus.ogamma_req) n_req++;
        if (bus.ogamma_new) n_new++;
        if (bus.oready) seen_ready = 1'b1;
        if (bus.owe) begin
            tx[bus.owaddr] = bus.owdata;
            wr_cnt[bus.owaddr]++;
            n_wr++;
            if (32'(bus.owaddr) > max_waddr) max_waddr = 32'(bus.owaddr);
            if (first_we == 0) first_we = cyc;
            last_we = cyc;
        end
        bus.igamma_valid = 1'b0;
        if (gcd != 0) begin
            gcd--;
            if (gcd == 0) begin
                bus.igamma_valid = 1'b1;
                if (gen_mode) begin
                    bus.igamma      = '0;
                    bus.igamma[3:0] = blk_ctr[3:0];
                end else begin
                    bus.igamma = 64'h0123_4567_89AB_CDEF;
                end
                blk_ctr++;
            end
        end
        if (bus.ogamma_req) gcd = lg;
    end

    task automatic step();
        @(posedge iclk);
        #1;
    endtask

    task automatic clear_tx();
        for (int i = 0; i < N; i++) begin
            tx[i]     = '0;
            wr_cnt[i] = 0;
        end
        n_wr = 0; n_req = 0; n_new = 0; max_waddr = 0;
        first_we = 0; last_we = 0; seen_ready = 1'b0;
    endtask

    task automatic wait_ready(input int unsigned limit, output int unsigned n);
        n = 0;
        while (!bus.oready && n < limit) begin
            step();
            n++;
        end
    endtask

    function automatic int unsigned bad_writes();
        int unsigned b = 0;
        for (int i = 0; i < N; i++) if (wr_cnt[i] != 1) b++;
        return b;
    endfunction

    initial begin
        vec_t        va [8];
        vec_t        vb [10];
        int unsigned n, cnt1, nz;

        va[0] = '{addr: 0,    exp: 4'h5};
        va[1] = '{addr: 1,    exp: 4'h4};
        va[2] = '{addr: 5,    exp: 4'h0};
        va[3] = '{addr: 8,    exp: 4'hD};
        va[4] = '{addr: 15,   exp: 4'hA};
        va[5] = '{addr: 16,   exp: 4'h5};
        va[6] = '{addr: 520,  exp: 4'hD};
        va[7] = '{addr: 1023, exp: 4'hA};

        vb[0] = '{addr: 0,    exp: 4'h0};
        vb[1] = '{addr: 1,    exp: 4'h1};
        vb[2] = '{addr: 16,   exp: 4'h1};
        vb[3] = '{addr: 17,   exp: 4'h1};
        vb[4] = '{addr: 32,   exp: 4'h2};
        vb[5] = '{addr: 240,  exp: 4'hF};
        vb[6] = '{addr: 256,  exp: 4'h0};
        vb[7] = '{addr: 272,  exp: 4'h1};
        vb[8] = '{addr: 1008, exp: 4'hF};
        vb[9] = '{addr: 1023, exp: 4'hF};

        bus.igen = 1'b0;
        bus.inew = 1'b0;
        for (int i = 0; i < N; i++) rx[i] = 4'hA;

        // Reset and idle
        repeat (4) step();
        check("reset_outputs", 64'({bus.oready, bus.ogamma_new, bus.ogamma_req, bus.owe,
                                    bus.oraddr, bus.owaddr, bus.owdata}), 64'd0);
        irst = 1'b0;
        clear_tx();
        nz = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if ({bus.oready, bus.ogamma_new, bus.ogamma_req, bus.owe,
                 bus.oraddr, bus.owaddr, bus.owdata} != 0) nz++;
        end
        check("idle_outputs_nonzero_cycles", 64'(nz), 64'd0);
        check("idle_req_count", 64'(n_req), 64'd0);

        // Rising inew held high: one pulse only
        bus.inew = 1'b1;
        repeat (10) step();
        check("inew_pulse_count", 64'(n_new), 64'd1);
        bus.inew = 1'b0;
        repeat (3) step();

        // Sector A: constant pad, Lg=3, igen together with rising inew
        clear_tx();
        gen_mode = 1'b0; blk_ctr = 0; lg = 3;
        bus.inew = 1'b1;
        bus.igen = 1'b1;
        step();
        check("sameclk_new_first", 64'(bus.ogamma_new), 64'd1);
        check("sameclk_no_req_yet", 64'(bus.ogamma_req), 64'd0);
        step();
        check("sameclk_req_next", 64'({bus.ogamma_new, bus.ogamma_req}), 64'b01);
        bus.inew = 1'b0;
        wait_ready(3000, n);
        check("sectA_cycles_to_ready", 64'(n + 2), 64'(EXP_A_CYC));
        check("sectA_req_count", 64'(n_req), 64'd64);
        check("sectA_write_count", 64'(n_wr), 64'd1024);
        check("sectA_addr_not_once", 64'(bad_writes()), 64'd0);
        for (int i = 0; i < 8; i++)
            check($sformatf("sectA_tx[%0d]", va[i].addr), 64'(tx[va[i].addr]), 64'(va[i].exp));
        cnt1 = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (bus.oready) cnt1++;
        end
        check("sectA_ready_held", 64'(cnt1), 64'd5);
        bus.igen = 1'b0;
        step();
        check("sectA_ready_drop", 64'(bus.oready), 64'd0);
        repeat (3) step();

        // Sector B: rx[i]=i, counter pad, Lg=5
        for (int i = 0; i < N; i++) rx[i] = 4'(i);
        clear_tx();
        gen_mode = 1'b1; blk_ctr = 0; lg = 5;
        bus.igen = 1'b1;
        wait_ready(3000, n);
        check("sectB_cycles_to_ready", 64'(n), 64'(EXP_B_CYC));
        check("sectB_addr_not_once", 64'(bad_writes()), 64'd0);
        for (int i = 0; i < 10; i++)
            check($sformatf("sectB_tx[%0d]", vb[i].addr), 64'(tx[vb[i].addr]), 64'(vb[i].exp));
`ifdef OTP_SCHED_PREFETCH_EN
        check("sectB_owe_span", 64'(last_we - first_we + 1), 64'd1024);
`endif
        bus.igen = 1'b0;
        repeat (3) step();

        // Abort mid-sector at cnt=100, then restart
        clear_tx();
        gen_mode = 1'b1; blk_ctr = 0; lg = 3;
        bus.igen = 1'b1;
        n = 0;
        while (bus.oraddr != 10'd100 && n < 2000) begin
            step();
            n++;
        end
        check("drop_reach_cnt100", 64'(n < 2000), 64'd1);
        bus.igen = 1'b0;
        repeat (40) step();
        check("drop_last_waddr", 64'(max_waddr), 64'd111);
        check("drop_write_count", 64'(n_wr), 64'd112);
        check("drop_no_ready", 64'(seen_ready), 64'd0);
        check("drop_req_count", 64'(n_req), 64'(EXP_DROP_RQ));
        clear_tx();
        bus.igen = 1'b1;
        wait_ready(3000, n);
        check("restart_ready_seen", 64'(n < 3000), 64'd1);
        check("restart_tx[0]", 64'(tx[0]), 64'(DROP_BLK % 16));
        check("restart_tx[16]", 64'(tx[16]), 64'((DROP_BLK + 1) % 16));
        check("restart_tx[33]", 64'(tx[33]), 64'd1);
        check("restart_addr_not_once", 64'(bad_writes()), 64'd0);
        bus.igen = 1'b0;
        repeat (3) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
